// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants, derived totals and the per-axis phase enum.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

endpackage

// File: rtl/sync_axis.sv
// One timing axis: position counter, ACTIVE->FRONT->SYNC->BACK phase FSM and sync decode.
// state  | meaning
// ACTIVE | visible region, pos < t_active
// FRONT  | front porch
// SYNC   | sync pulse, sync_lvl = SYNC_POL
// BACK   | back porch, wraps to ACTIVE at pos 0
module sync_axis
    import vga_timing_pkg::*;
#(
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    input  logic [9:0] t_active,
    input  logic [9:0] t_fp,
    input  logic [9:0] t_sync,
    input  logic [9:0] t_bp,
    output logic [9:0] pos,
    output phase_t     phase,
    output logic       wrap,
    output logic       sync_lvl
);

    logic [9:0] b_sync;
    logic [9:0] b_back;
    logic [9:0] last;
    logic [9:0] pos_d, pos_q;
    phase_t     phase_d, phase_q;
    logic       sync_d, sync_q;

    assign b_sync = t_active + t_fp;
    assign b_back = b_sync + t_sync;
    assign last   = b_back + t_bp - 10'd1;

    always_comb begin
        pos_d   = pos_q;
        phase_d = phase_q;
        wrap    = adv && (pos_q == last);
        if (adv) begin
            pos_d = wrap ? 10'd0 : pos_q + 10'd1;
            if (pos_d == t_active)     phase_d = FRONT;
            else if (pos_d == b_sync)  phase_d = SYNC;
            else if (pos_d == b_back)  phase_d = BACK;
            else if (pos_d == 10'd0)   phase_d = ACTIVE;
        end
        sync_d = (phase_d == SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q   <= 10'd0;
            phase_q <= ACTIVE;
            sync_q  <= ~SYNC_POL;
        end else begin
            pos_q   <= pos_d;
            phase_q <= phase_d;
            sync_q  <= sync_d;
        end
    end

    // phase is the value being loaded this cycle so the parent can register
    // decodes that line up with pos.
    assign pos      = pos_q;
    assign phase    = phase_d;
    assign sync_lvl = sync_q;

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: two sync_axis instances (pixel and line) plus registered
// video_on / line_start / frame_start decoded from next-state values.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       beat,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    logic       arm_q;
    logic       beat_en;
    logic       h_wrap, v_wrap;
    phase_t     h_phase, v_phase;
    logic       video_on_d, video_on_q;
    logic       line_start_d, line_start_q;
    logic       frame_start_d, frame_start_q;

    // A beat coinciding with reset release is dropped; arm_q opens the gate one clk later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) arm_q <= 1'b0;
        else        arm_q <= 1'b1;
    end

    assign beat_en = beat & arm_q;

    sync_axis #(.SYNC_POL(SYNC_POL)) u_h_axis (
        .clk      (clk),
        .reset    (reset),
        .adv      (beat_en),
        .t_active (10'(H_ACTIVE)),
        .t_fp     (10'(H_FP)),
        .t_sync   (10'(H_SYNC)),
        .t_bp     (10'(H_BP)),
        .pos      (pixel_x),
        .phase    (h_phase),
        .wrap     (h_wrap),
        .sync_lvl (hsync)
    );

    sync_axis #(.SYNC_POL(SYNC_POL)) u_v_axis (
        .clk      (clk),
        .reset    (reset),
        .adv      (h_wrap),
        .t_active (10'(V_ACTIVE)),
        .t_fp     (10'(V_FP)),
        .t_sync   (10'(V_SYNC)),
        .t_bp     (10'(V_BP)),
        .pos      (pixel_y),
        .phase    (v_phase),
        .wrap     (v_wrap),
        .sync_lvl (vsync)
    );

    always_comb begin
        video_on_d    = (h_phase == ACTIVE) && (v_phase == ACTIVE);
        line_start_d  = h_wrap;
        frame_start_d = h_wrap && v_wrap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            video_on_q    <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: H_ACTIVE 640 visible pixels per line; H_FP 16 front-porch pixels; H_SYNC 96 sync pixels; H_BP 48 back-porch pixels; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; SYNC_POL 0 (sync asserted level).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 beat  input  1  pixel-enable strobe, one clk wide, from the upstream clock divider; one beat advances one pixel.
REQ-005 hsync  output  1  horizontal sync; equals SYNC_POL during the H sync phase, otherwise ~SYNC_POL.
REQ-006 vsync  output  1  vertical sync; equals SYNC_POL during the V sync phase, otherwise ~SYNC_POL.
REQ-007 video_on  output  1  high when the current pixel is in both H and V active regions.
REQ-008 pixel_x  output  10  horizontal pixel position, 0..H_TOTAL-1.
REQ-009 pixel_y  output  10  vertical line position, 0..V_TOTAL-1.
REQ-010 line_start  output  1  one-clk pulse when pixel_x changes to 0.
REQ-011 frame_start  output  1  one-clk pulse when both pixel_x and pixel_y change to 0.

Function
REQ-012 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default), and V_TOTAL SHALL be the same sum for V (525 by default); both SHALL fit in 10 bits.
REQ-013 Counters SHALL change only in clk cycles where beat=1; with beat=0, every output SHALL hold, and line_start and frame_start SHALL be 0.
REQ-014 On beat, pixel_x SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and pixel_y SHALL advance by one in the same cycle.
REQ-015 pixel_y SHALL wrap from V_TOTAL-1 to 0 only when pixel_x also wraps.
REQ-016 Each axis SHALL carry an explicit phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
REQ-016a A phase transition SHALL occur on the counter step entering the first position of the next phase: x=H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, and 0 for the horizontal axis, with the V equivalents for the vertical axis.
REQ-017 hsync, vsync, video_on, line_start and frame_start SHALL be registered and decoded from next-state values, so they are valid in the same cycle as the pixel_x/pixel_y they describe (zero relative latency, no combinational output path).
REQ-018 When beat is asserted on every clk, the bench SHALL see consecutive frames exactly H_TOTAL*V_TOTAL clks apart (420000 by default).
REQ-019 A beat arriving in the same cycle that reset releases SHALL be ignored; the first counted beat is the next one.

Reset
REQ-020 While reset=0: pixel_x=0, pixel_y=0, both FSMs in ACTIVE, video_on=1, hsync=vsync=~SYNC_POL, line_start=0, frame_start=0.
REQ-021 Reset assertion mid-line or mid-frame SHALL force REQ-020 values immediately, without waiting for clk.
REQ-022 After release, the first beat SHALL produce pixel_x=1, pixel_y=0.

Structure
REQ-023 Package vga_timing_pkg SHALL hold the default timing constants, the derived totals, and the phase enum {ACTIVE, FRONT, SYNC, BACK}.
REQ-024 The block SHALL contain one sub-module, sync_axis, instantiated twice.
REQ-024a sync_axis SHALL consist of a counter, a phase FSM and a sync decode, and SHALL take the advance enable and the timing parameters as inputs.
REQ-024b sync_axis SHALL output position, phase, a wrap flag and the sync level.

Verification
REQ-025 Reset low 3 clks, then beat=1 every clk for 800 clks -> pixel_x runs 0..799 then 0; hsync low for exactly x=656..751; line_start pulses at x=0; pixel_y=1 after the wrap.
REQ-026 beat=1 continuously for 2 full frames -> frame_start pulses exactly 420000 clks apart; vsync low for lines 490..491 only (1600 clks per frame).
REQ-027 beat every 17th clk -> counters and outputs change only on beat cycles; line_start is never asserted on a cycle where beat=0.
REQ-028 Assert reset at x=700, y=300 between clk edges -> outputs reach REQ-020 values before the next clk edge; the first post-release beat gives x=1, y=0.
REQ-029 Full frame with checker -> video_on=1 exactly when x<640 and y<480 (307200 active pixels per frame).
REQ-030 SYNC_POL=1 build -> hsync/vsync are inverted relative to REQ-025 and REQ-026 with identical timing.
